// File: rtl/bus_control_sequencer_if.sv
// Enable/strobe bundle between the bus control sequencer and the datapath.
// The sequencer is the master: it takes start and the IR word, and drives
// every enable, select and status signal.
interface bus_control_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic [24:0] out_en;
  logic [24:0] in_en;
  logic        read;
  logic [5:0]  alu_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  modport master (
    input  start, ir,
    output out_en, in_en, read, alu_sel, busy, done, err, instr_count
  );

  modport slave (
    output start, ir,
    input  out_en, in_en, read, alu_sel, busy, done, err, instr_count
  );
endinterface

// File: rtl/bus_control_sequencer.sv
// Fetch/execute sequencer for the shared 32-bit bus datapath. It walks
// T0..T6 and drives the one-hot bus source enables, the register loads,
// the MDR read select and the ALU op. Outputs are decoded from the state
// register and the live IR, because IR only settles at the start of T3.
module bus_control_sequencer (
  input  logic                          clock,
  input  logic                          clr,
  bus_control_sequencer_if.master       bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  // Bus bit positions for the special registers
  localparam int HI_B   = 16;
  localparam int LO_B   = 17;
  localparam int ZHI_B  = 18;
  localparam int ZLO_B  = 19;
  localparam int PC_B   = 20;
  localparam int IR_B   = 21;
  localparam int MDR_B  = 22;
  localparam int MAR_B  = 23;
  localparam int Y_B    = 24;

  localparam logic [4:0] OP_MUL  = 5'h10;
  localparam logic [4:0] OP_DIV  = 5'h11;
  localparam logic [4:0] OP_NOP  = 5'h1E;
  localparam logic [4:0] OP_HALT = 5'h1F;

  state_t      state;
  logic [15:0] instr_count_q;
  logic        err_q;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_rtype, is_muldiv;

  logic [24:0] out_en_c, in_en_c;
  logic        read_c;
  logic [5:0]  alu_sel_c;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign is_rtype  = (opcode[4] == 1'b0);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

  // State, fetch counter and sticky error; reset wins over everything
  always_ff @(posedge clock) begin
    if (!clr) begin
      state         <= IDLE;
      instr_count_q <= 16'h0000;
      err_q         <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (bus.start) state <= T0;
        T0:     state <= T1;
        T1:     state <= T2;
        T2: begin
          state         <= T3;
          instr_count_q <= instr_count_q + 16'd1;
        end
        T3: begin
          if (is_rtype || is_muldiv) state <= T4;
          else if (opcode == OP_NOP) state <= T0;
          else if (opcode == OP_HALT) state <= HALTED;
          else begin
            err_q <= 1'b1;
            state <= HALTED;
          end
        end
        T4:     state <= T5;
        T5:     state <= is_muldiv ? T6 : T0;
        T6:     state <= T0;
        HALTED: begin
          if (bus.start) begin
            err_q <= 1'b0;
            state <= T0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-state control word; everything idles at zero
  always_comb begin
    out_en_c  = '0;
    in_en_c   = '0;
    read_c    = 1'b0;
    alu_sel_c = '0;
    case (state)
      T0: begin
        out_en_c[PC_B]   = 1'b1;
        in_en_c[MAR_B]   = 1'b1;
        in_en_c[ZHI_B]   = 1'b1;
        in_en_c[ZLO_B]   = 1'b1;
        alu_sel_c        = 6'd32;
      end
      T1: begin
        out_en_c[ZLO_B]  = 1'b1;
        in_en_c[PC_B]    = 1'b1;
        in_en_c[MDR_B]   = 1'b1;
        read_c           = 1'b1;
      end
      T2: begin
        out_en_c[MDR_B]  = 1'b1;
        in_en_c[IR_B]    = 1'b1;
      end
      T3: begin
        if (is_rtype || is_muldiv) begin
          out_en_c       = 25'(1) << rb;
          in_en_c[Y_B]   = 1'b1;
        end
      end
      T4: begin
        out_en_c         = 25'(1) << rc;
        in_en_c[ZHI_B]   = 1'b1;
        in_en_c[ZLO_B]   = 1'b1;
        alu_sel_c        = {1'b0, opcode};
      end
      T5: begin
        out_en_c[ZLO_B]  = 1'b1;
        if (is_muldiv) in_en_c[LO_B] = 1'b1;
        else           in_en_c       = 25'(1) << ra;
      end
      T6: begin
        out_en_c[ZHI_B]  = 1'b1;
        in_en_c[HI_B]    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.out_en      = out_en_c;
  assign bus.in_en       = in_en_c;
  assign bus.read        = read_c;
  assign bus.alu_sel     = alu_sel_c;
  assign bus.busy        = (state != IDLE) && (state != HALTED);
  assign bus.done        = (state == HALTED);
  assign bus.err         = err_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Vector-table bench for bus_control_sequencer: each record gives the inputs
// for one clock edge and the outputs expected after it; records go through a
// scoreboard queue. A free-running monitor checks out_en popcount <= 1.
module tb_bus_control_sequencer;

  logic clock = 1'b0;
  logic clr   = 1'b0;

  bus_control_sequencer_if bus ();

  bus_control_sequencer dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic [24:0] oe;
    logic [24:0] ie;
    logic        rd;
    logic [5:0]  alu;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic mon_on     = 1'b0;

  localparam logic [31:0] IR_ADD  = 32'h1922_8000; // op 03 ra2 rb4 rc5
  localparam logic [31:0] IR_MUL  = 32'h8008_8000; // op 10 ra0 rb1 rc1
  localparam logic [31:0] IR_HALT = 32'hF800_0000; // op 1F
  localparam logic [31:0] IR_ILL  = 32'hA800_0000; // op 15
  localparam logic [31:0] IR_NOP  = 32'hF000_0000; // op 1E

  localparam logic [24:0] T0_OE = 25'h010_0000, T0_IE = 25'h08C_0000;
  localparam logic [24:0] T1_OE = 25'h008_0000, T1_IE = 25'h050_0000;
  localparam logic [24:0] T2_OE = 25'h040_0000, T2_IE = 25'h020_0000;

  task automatic add(input string n, input logic c, input logic s, input logic [31:0] i,
                     input logic [24:0] oe, input logic [24:0] ie, input logic rd,
                     input logic [5:0] alu, input logic b, input logic d, input logic e,
                     input logic [15:0] cnt);
    vec_t v;
    v.name = n; v.clr = c; v.start = s; v.ir = i; v.oe = oe; v.ie = ie; v.rd = rd;
    v.alu = alu; v.busy = b; v.done = d; v.err = e; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Drive one record, clock it, then compare against the scoreboard head
  task automatic apply(input vec_t v);
    vec_t e;
    clr       = v.clr;
    bus.start = v.start;
    bus.ir    = v.ir;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    compared++;
    if (bus.out_en !== e.oe || bus.in_en !== e.ie || bus.read !== e.rd ||
        bus.alu_sel !== e.alu || bus.busy !== e.busy || bus.done !== e.done ||
        bus.err !== e.err || bus.instr_count !== e.cnt) begin
      mismatched++;
      $display("FAIL %s: got oe=%h ie=%h rd=%b alu=%0d busy=%b done=%b err=%b cnt=%h want oe=%h ie=%h rd=%b alu=%0d busy=%b done=%b err=%b cnt=%h",
               e.name, bus.out_en, bus.in_en, bus.read, bus.alu_sel, bus.busy, bus.done,
               bus.err, bus.instr_count, e.oe, e.ie, e.rd, e.alu, e.busy, e.done, e.err, e.cnt);
    end
  endtask

  task automatic run_table();
    while (tbl.size() > 0) apply(tbl.pop_front());
  endtask

  // Bus-source invariant, sampled mid-cycle
  always @(negedge clock) begin
    if (mon_on) begin
      compared++;
      if ($countones(bus.out_en) > 1) begin
        mismatched++;
        $display("FAIL onehot: out_en=%h popcount=%0d want <=1", bus.out_en, $countones(bus.out_en));
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.ir    = IR_ADD;
    mon_on    = 1'b1;

    // reset and idle
    add("rst0",   0,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("rst1",   0,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("idle0",  1,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("idle1",  1,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("idle2",  1,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    // R-type add r2 = r4 + r5 (start re-pulsed in T3 must be ignored)
    add("add_t0", 1,1,IR_ADD, T0_OE,T0_IE,0,32, 1,0,0, 16'h0);
    add("add_t1", 1,0,IR_ADD, T1_OE,T1_IE,1,0, 1,0,0, 16'h0);
    add("add_t2", 1,0,IR_ADD, T2_OE,T2_IE,0,0, 1,0,0, 16'h0);
    add("add_t3", 1,0,IR_ADD, 25'h10,25'h100_0000,0,0, 1,0,0, 16'h1);
    add("add_t4", 1,1,IR_ADD, 25'h20,25'h0C_0000,0,3, 1,0,0, 16'h1);
    add("add_t5", 1,0,IR_ADD, 25'h8_0000,25'h4,0,0, 1,0,0, 16'h1);
    add("add_nx", 1,0,IR_ADD, T0_OE,T0_IE,0,32, 1,0,0, 16'h1);
    // mul, rb == rc
    add("mul_t1", 1,0,IR_MUL, T1_OE,T1_IE,1,0, 1,0,0, 16'h1);
    add("mul_t2", 1,0,IR_MUL, T2_OE,T2_IE,0,0, 1,0,0, 16'h1);
    add("mul_t3", 1,0,IR_MUL, 25'h2,25'h100_0000,0,0, 1,0,0, 16'h2);
    add("mul_t4", 1,0,IR_MUL, 25'h2,25'h0C_0000,0,16, 1,0,0, 16'h2);
    add("mul_t5", 1,0,IR_MUL, 25'h8_0000,25'h2_0000,0,0, 1,0,0, 16'h2);
    add("mul_t6", 1,0,IR_MUL, 25'h4_0000,25'h1_0000,0,0, 1,0,0, 16'h2);
    // halt
    add("hlt_t0", 1,0,IR_HALT, T0_OE,T0_IE,0,32, 1,0,0, 16'h2);
    add("hlt_t1", 1,0,IR_HALT, T1_OE,T1_IE,1,0, 1,0,0, 16'h2);
    add("hlt_t2", 1,0,IR_HALT, T2_OE,T2_IE,0,0, 1,0,0, 16'h2);
    add("hlt_t3", 1,0,IR_HALT, 0,0,0,0, 1,0,0, 16'h3);
    add("hlt_h0", 1,0,IR_HALT, 0,0,0,0, 0,1,0, 16'h3);
    add("hlt_h1", 1,0,IR_HALT, 0,0,0,0, 0,1,0, 16'h3);
    // illegal opcode 0x15 after restart
    add("ill_t0", 1,1,IR_ILL, T0_OE,T0_IE,0,32, 1,0,0, 16'h3);
    add("ill_t1", 1,0,IR_ILL, T1_OE,T1_IE,1,0, 1,0,0, 16'h3);
    add("ill_t2", 1,0,IR_ILL, T2_OE,T2_IE,0,0, 1,0,0, 16'h3);
    add("ill_t3", 1,0,IR_ILL, 0,0,0,0, 1,0,0, 16'h4);
    add("ill_h0", 1,0,IR_ILL, 0,0,0,0, 0,1,1, 16'h4);
    add("ill_h1", 1,0,IR_ILL, 0,0,0,0, 0,1,1, 16'h4);
    // restart clears err; reset lands mid-execute in T4
    add("rs_t0",  1,1,IR_ADD, T0_OE,T0_IE,0,32, 1,0,0, 16'h4);
    add("rs_t1",  1,0,IR_ADD, T1_OE,T1_IE,1,0, 1,0,0, 16'h4);
    add("rs_t2",  1,0,IR_ADD, T2_OE,T2_IE,0,0, 1,0,0, 16'h4);
    add("rs_t3",  1,0,IR_ADD, 25'h10,25'h100_0000,0,0, 1,0,0, 16'h5);
    add("rs_t4",  1,0,IR_ADD, 25'h20,25'h0C_0000,0,3, 1,0,0, 16'h5);
    add("rs_clr", 0,1,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("rs_id0", 1,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    add("rs_id1", 1,0,IR_ADD, 0,0,0,0, 0,0,0, 16'h0);
    run_table();

    // Counter wrap: preload the fetch counter near the top while idle,
    // then back-to-back nops carry it through 0xFFFF -> 0x0000
    force dut.instr_count_q = 16'hFFFE;
    #1;
    release dut.instr_count_q;
    add("nop_t0a", 1,1,IR_NOP, T0_OE,T0_IE,0,32, 1,0,0, 16'hFFFE);
    add("nop_t1a", 1,0,IR_NOP, T1_OE,T1_IE,1,0, 1,0,0, 16'hFFFE);
    add("nop_t2a", 1,0,IR_NOP, T2_OE,T2_IE,0,0, 1,0,0, 16'hFFFE);
    add("nop_t3a", 1,0,IR_NOP, 0,0,0,0, 1,0,0, 16'hFFFF);
    add("nop_t0b", 1,0,IR_NOP, T0_OE,T0_IE,0,32, 1,0,0, 16'hFFFF);
    add("nop_t1b", 1,0,IR_NOP, T1_OE,T1_IE,1,0, 1,0,0, 16'hFFFF);
    add("nop_t2b", 1,0,IR_NOP, T2_OE,T2_IE,0,0, 1,0,0, 16'hFFFF);
    add("nop_wrap",1,0,IR_NOP, 0,0,0,0, 1,0,0, 16'h0000);
    add("nop_t0c", 1,0,IR_NOP, T0_OE,T0_IE,0,32, 1,0,0, 16'h0000);
    add("nop_rst", 0,0,IR_NOP, 0,0,0,0, 0,0,0, 16'h0000);
    run_table();

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
